// File: rtl/raster_pkg.sv
// Shared constants for the scanline rasterizer: default VGA timing, uv mapping
// encodings and the registered fragment layout.
package raster_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_TW       = 7;

  // uv_mode 0: u=b_z, v=b_y+b_z; uv_mode 1: u=b_y+b_z, v=b_y
  localparam logic UV_Z_SUM = 1'b0;
  localparam logic UV_SUM_Y = 1'b1;

  // Fragment word, MSB first: {hit, tri, back, u, v}
  function automatic int tri_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int frag_w(int n, int tw);
    return 2 + tri_w(n) + 2 * tw;
  endfunction
endpackage

// File: rtl/raster_n_if.sv
// Fragment output bundle from the rasterizer to the shading stage.
interface raster_n_if
  import raster_pkg::*;
#(
  parameter int TRI_W = 1,
  parameter int TW    = DEF_TW
);
  logic             frag_valid;
  logic             frag_hit;
  logic [TRI_W-1:0] frag_tri;
  logic             frag_back;
  logic [TW-1:0]    frag_u;
  logic [TW-1:0]    frag_v;

  modport master (output frag_valid, frag_hit, frag_tri, frag_back, frag_u, frag_v);
  modport slave  (input  frag_valid, frag_hit, frag_tri, frag_back, frag_u, frag_v);
endinterface

// File: rtl/raster_tri_eval.sv
// One triangle: incremental edge/barycentric accumulators, coverage test and
// texture coordinate selection.
module raster_tri_eval
  import raster_pkg::*;
#(
  parameter int EW = 20,
  parameter int BW = 22,
  parameter int TW = DEF_TW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [3*EW-1:0] edge_init,
  input  logic [3*EW-1:0] edge_dx,
  input  logic [2*BW-1:0] bar_init,
  input  logic [2*BW-1:0] bar_dx,
  input  logic            en,
  input  logic            uv_mode,
  input  logic            cull_back,
  output logic            cov_front,
  output logic            cov_back,
  output logic [TW-1:0]   u,
  output logic [TW-1:0]   v
);
  logic [2:0][EW-1:0] e;
  logic [BW-1:0]      b_y, b_z, b_sum;
  logic [2:0]         neg, pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      e   <= '0;
      b_y <= '0;
      b_z <= '0;
    end else if (load) begin
      e   <= edge_init;
      b_y <= bar_init[BW-1:0];
      b_z <= bar_init[2*BW-1:BW];
    end else if (step) begin
      for (int j = 0; j < 3; j++) e[j] <= e[j] + edge_dx[j*EW +: EW];
      b_y <= b_y + bar_dx[BW-1:0];
      b_z <= b_z + bar_dx[2*BW-1:BW];
    end
  end

  // A zero edge is neither negative nor positive, so it never covers.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      neg[j] = e[j][EW-1];
      pos[j] = !e[j][EW-1] && (e[j] != '0);
    end
  end

  assign cov_front = en && (&neg);
  assign cov_back  = en && (&pos) && !cull_back;
  assign b_sum     = b_y + b_z;
  assign u = (uv_mode == UV_SUM_Y) ? b_sum[BW-3 -: TW] : b_z[BW-3 -: TW];
  assign v = (uv_mode == UV_SUM_Y) ? b_y[BW-3 -: TW]   : b_sum[BW-3 -: TW];
endmodule

// File: rtl/raster_n.sv
// Scanline rasterizer top: pixel phase, region decode, lowest-index priority
// resolve across NUM_TRI triangle evaluators, registered fragment output.
module raster_n
  import raster_pkg::*;
#(
  parameter int NUM_TRI  = 2,
  parameter int EW       = 20,
  parameter int BW       = 22,
  parameter int TW       = DEF_TW,
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_TOTAL  = DEF_V_TOTAL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic [NUM_TRI*3*EW-1:0] edge_init,
  input  logic [NUM_TRI*3*EW-1:0] edge_dx,
  input  logic [NUM_TRI*2*BW-1:0] bar_init,
  input  logic [NUM_TRI*2*BW-1:0] bar_dx,
  input  logic [NUM_TRI-1:0]      tri_en,
  input  logic [NUM_TRI-1:0]      uv_mode,
  input  logic                    cull_back,
  raster_n_if.master              frag
);
  localparam int TRI_W = tri_w(NUM_TRI);
  localparam int FW    = frag_w(NUM_TRI, TW);

  logic [1:0]    ph;
  logic          armed;
  logic          load, active, eval;
  logic [NUM_TRI-1:0]         cov_front, cov_back;
  logic [NUM_TRI-1:0][TW-1:0] u_all, v_all;
  logic             hit, back;
  logic [TRI_W-1:0] win;
  logic [TW-1:0]    win_u, win_v;
  logic             valid_q;
  logic [FW-1:0]    frag_q;

  assign load   = (x == 10'(H_TOTAL - 1)) &&
                  ((y < 10'(V_ACTIVE)) || (y == 10'(V_TOTAL - 1)));
  assign active = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
  // armed is cleared by reset so that no fragment comes out of zeroed
  // accumulators before the setup stage has loaded a fresh line.
  assign eval   = active && armed && !load && (ph == 2'(PIX_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      ph    <= '0;
      armed <= 1'b0;
    end else if (load) begin
      ph    <= '0;
      armed <= 1'b1;
    end else if (active) begin
      ph <= (ph == 2'(PIX_DIV - 1)) ? 2'd0 : ph + 2'd1;
    end
  end

  for (genvar g = 0; g < NUM_TRI; g++) begin : g_tri
    raster_tri_eval #(.EW(EW), .BW(BW), .TW(TW)) u_tri (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (eval),
      .edge_init (edge_init[g*3*EW +: 3*EW]),
      .edge_dx   (edge_dx[g*3*EW +: 3*EW]),
      .bar_init  (bar_init[g*2*BW +: 2*BW]),
      .bar_dx    (bar_dx[g*2*BW +: 2*BW]),
      .en        (tri_en[g]),
      .uv_mode   (uv_mode[g]),
      .cull_back (cull_back),
      .cov_front (cov_front[g]),
      .cov_back  (cov_back[g]),
      .u         (u_all[g]),
      .v         (v_all[g])
    );
  end

  // Scan from the top so the lowest covering index is the last to write.
  always_comb begin
    hit   = 1'b0;
    back  = 1'b0;
    win   = '0;
    win_u = '0;
    win_v = '0;
    for (int i = NUM_TRI - 1; i >= 0; i--) begin
      if (cov_front[i] || cov_back[i]) begin
        hit   = 1'b1;
        back  = !cov_front[i];
        win   = TRI_W'(i);
        win_u = u_all[i];
        win_v = v_all[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      frag_q  <= '0;
    end else begin
      valid_q <= eval;
      if (eval) frag_q <= hit ? {1'b1, win, back, win_u, win_v} : '0;
    end
  end

  assign frag.frag_valid = valid_q;
  assign frag.frag_hit   = frag_q[FW-1];
  assign frag.frag_tri   = frag_q[FW-2 -: TRI_W];
  assign frag.frag_back  = frag_q[2*TW];
  assign frag.frag_u     = frag_q[2*TW-1 -: TW];
  assign frag.frag_v     = frag_q[TW-1:0];
endmodule
